// File: rtl/refclk_ctrl_pkg.sv
// refclk_ctrl_pkg: shared types and sizing helpers for the refclk CEB controller. Rev 1.0
`default_nettype none

package refclk_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HOLD    = 3'd1,
    S_SETTLE  = 3'd2,
    S_MEASURE = 3'd3,
    S_LOCKED  = 3'd4,
    S_FAULT   = 3'd5
  } state_t;

  localparam int c_RETRY_W = 4;

  // Timer must reach the longest of the three phase lengths minus one.
  function automatic int tmr_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_rise_det.sv
// sync_rise_det: 2-FF synchronizer with a single-cycle rising-edge pulse. Rev 1.0
`default_nettype none

module sync_rise_det (
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_async,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/refclk_ceb_ctrl.sv
// refclk_ceb_ctrl: CEB power-up sequencing and heartbeat-window qualification of a GT refclk. Rev 1.0
`default_nettype none

module refclk_ceb_ctrl
  import refclk_ctrl_pkg::*;
#(
  parameter int CEB_HOLD_CYC = 64,
  parameter int SETTLE_CYC   = 1024,
  parameter int WINDOW_CYC   = 4096,
  parameter int CNT_W        = 16,
  parameter int CNT_MIN      = 480,
  parameter int CNT_MAX      = 544,
  parameter int MAX_RETRY    = 3
) (
  input  logic                 CLK,
  input  logic                 RSTN,
  input  logic                 EN,
  input  logic                 HEARTBEAT,
  output logic                 CEB,
  output logic                 REFCLK_OK,
  output logic                 FAULT,
  output logic [CNT_W-1:0]     EDGE_CNT,
  output logic [c_RETRY_W-1:0] RETRY_CNT
);

  localparam int c_TMR_W = tmr_width(CEB_HOLD_CYC, SETTLE_CYC, WINDOW_CYC);
  localparam logic [c_TMR_W-1:0]   c_HOLD_LAST   = c_TMR_W'(CEB_HOLD_CYC - 1);
  localparam logic [c_TMR_W-1:0]   c_SETTLE_LAST = c_TMR_W'(SETTLE_CYC - 1);
  localparam logic [c_TMR_W-1:0]   c_WIN_LAST    = c_TMR_W'(WINDOW_CYC - 1);
  localparam logic [c_RETRY_W-1:0] c_RETRY_MAX   = c_RETRY_W'(MAX_RETRY);

  state_t               r_state;
  logic [c_TMR_W-1:0]   r_timer;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_rise;
  logic [CNT_W-1:0]     w_cnt_next;
  logic                 w_pass;
  logic                 w_win_end;
  logic [c_RETRY_W-1:0] w_retry_inc;

  sync_rise_det u_hb_sync (
    .i_clk   (CLK),
    .i_rstn  (RSTN),
    .i_async (HEARTBEAT),
    .o_rise  (w_rise)
  );

  always_comb begin
    w_cnt_next = r_cnt;
    if (w_rise && !(&r_cnt)) w_cnt_next = r_cnt + CNT_W'(1);
  end

  // Compared at 32 bits so a CNT_MAX beyond the counter range still works.
  assign w_pass      = (32'(w_cnt_next) >= 32'(CNT_MIN)) && (32'(w_cnt_next) <= 32'(CNT_MAX));
  assign w_win_end   = (r_timer == c_WIN_LAST);
  assign w_retry_inc = RETRY_CNT + c_RETRY_W'(1);

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_cnt     <= '0;
      CEB       <= 1'b1;
      REFCLK_OK <= 1'b0;
      FAULT     <= 1'b0;
      EDGE_CNT  <= '0;
      RETRY_CNT <= '0;
    end else if (!EN) begin
      r_state   <= S_IDLE;
      r_timer   <= '0;
      r_cnt     <= '0;
      CEB       <= 1'b1;
      REFCLK_OK <= 1'b0;
      FAULT     <= 1'b0;
      RETRY_CNT <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_HOLD;
          r_timer <= '0;
          CEB     <= 1'b1;
        end
        S_HOLD: begin
          if (r_timer == c_HOLD_LAST) begin
            r_state <= S_SETTLE;
            r_timer <= '0;
            CEB     <= 1'b0;
          end else begin
            r_timer <= r_timer + c_TMR_W'(1);
          end
        end
        S_SETTLE: begin
          if (r_timer == c_SETTLE_LAST) begin
            r_state <= S_MEASURE;
            r_timer <= '0;
            r_cnt   <= '0;
          end else begin
            r_timer <= r_timer + c_TMR_W'(1);
          end
        end
        S_MEASURE, S_LOCKED: begin
          if (!w_win_end) begin
            r_timer <= r_timer + c_TMR_W'(1);
            r_cnt   <= w_cnt_next;
          end else begin
            r_timer  <= '0;
            r_cnt    <= '0;
            EDGE_CNT <= w_cnt_next;
            if (w_pass) begin
              r_state   <= S_LOCKED;
              REFCLK_OK <= 1'b1;
              RETRY_CNT <= '0;
            end else if (r_state == S_LOCKED) begin
              r_state   <= S_HOLD;
              CEB       <= 1'b1;
              REFCLK_OK <= 1'b0;
              RETRY_CNT <= c_RETRY_W'(1);
            end else begin
              RETRY_CNT <= w_retry_inc;
              CEB       <= 1'b1;
              if (w_retry_inc == c_RETRY_MAX) begin
                r_state <= S_FAULT;
                FAULT   <= 1'b1;
              end else begin
                r_state <= S_HOLD;
              end
            end
          end
        end
        S_FAULT: begin
          CEB   <= 1'b1;
          FAULT <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
